// File: rtl/prio_enc_q_if.sv
// Request/grant bundle for prio_enc_q: request capture inputs plus the valid/ready grant stage.
interface prio_enc_q_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned IDXW = $clog2(N);

  logic            en;
  logic [N-1:0]    req;
  logic            out_ready;
  logic            out_valid;
  logic [IDXW-1:0] out_idx;
  logic [N-1:0]    out_onehot;
  logic            out_multi;
  logic            busy;

  // Request source / consumer side
  modport master (
    output en, req, out_ready,
    input  out_valid, out_idx, out_onehot, out_multi, busy
  );

  // Encoder side
  modport slave (
    input  en, req, out_ready,
    output out_valid, out_idx, out_onehot, out_multi, busy
  );
endinterface

// File: rtl/prio_enc_q.sv
// Registered priority encoder: latches requests as sticky pending bits and issues one
// encoded grant per handshake, using fixed-priority or round-robin selection.
module prio_enc_q #(
  parameter int unsigned N  = 8,
  parameter int unsigned RR = 0
) (
  input logic         clk,
  input logic         rst_n,
  prio_enc_q_if.slave bus
);
  localparam int unsigned IDXW = $clog2(N);

  logic [N-1:0]    pend_q, pend_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic            multi_q, multi_d;

  logic [N-1:0]    pend_eff;
  logic            load;
  logic            any_req;
  logic [IDXW-1:0] lo_idx, hi_idx, win;
  logic            hi_found;

  // Merge newly captured requests with pending ones; slot is free or draining this cycle
  always_comb begin
    pend_eff = pend_q | (bus.en ? bus.req : '0);
    load     = !valid_q || bus.out_ready;
    any_req  = |pend_eff;
  end

  // Winner: lowest set bit overall, or lowest set bit at/above ptr in round-robin mode
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    // Descending scan so the last hit is the lowest index
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_eff[i]) begin
        lo_idx = IDXW'(i);
        if (IDXW'(i) >= ptr_q) begin
          hi_idx   = IDXW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = ((RR != 0) && hi_found) ? hi_idx : lo_idx;
  end

  // Next-state: grant on a free slot, otherwise accumulate requests while stalled
  always_comb begin
    pend_d   = pend_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    multi_d  = multi_q;
    if (load) begin
      if (any_req) begin
        valid_d  = 1'b1;
        idx_d    = win;
        onehot_d = N'(1) << win;
        // More than one bit set iff clearing the lowest set bit leaves something
        multi_d  = |(pend_eff & (pend_eff - N'(1)));
        // Granted bit is consumed even if its req is still high this cycle
        pend_d   = pend_eff & ~(N'(1) << win);
        if (RR != 0) begin
          ptr_d = (win == IDXW'(N - 1)) ? '0 : win + 1'b1;
        end
      end else begin
        valid_d = 1'b0;
        pend_d  = '0;
      end
    end else begin
      pend_d = pend_eff;
    end
  end

  // State registers; reset discards pending and in-flight grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_multi  = multi_q;
  assign bus.busy       = (|pend_q) | valid_q;

endmodule

// File: tb/tb_prio_enc_q.sv
// Scoreboard bench for prio_enc_q: a fixed-priority and a round-robin instance driven
// with the same stimulus; expected grants are queued per instance and popped on handshake.
module tb_prio_enc_q;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  prio_enc_q_if #(.N(N)) if_fp ();
  prio_enc_q_if #(.N(N)) if_rr ();

  prio_enc_q #(.N(N), .RR(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp));
  prio_enc_q #(.N(N), .RR(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));

  typedef struct packed {
    logic [2:0] idx;
    logic       multi;
  } exp_t;

  exp_t q_fp[$];
  exp_t q_rr[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] r, input logic rdy);
    if_fp.en = e; if_fp.req = r; if_fp.out_ready = rdy;
    if_rr.en = e; if_rr.req = r; if_rr.out_ready = rdy;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_fp(input int idx, input logic multi);
    exp_t e;
    e.idx = 3'(idx);
    e.multi = multi;
    q_fp.push_back(e);
  endtask

  task automatic push_rr(input int idx, input logic multi);
    exp_t e;
    e.idx = 3'(idx);
    e.multi = multi;
    q_rr.push_back(e);
  endtask

  task automatic push2(input int idx, input logic multi);
    push_fp(idx, multi);
    push_rr(idx, multi);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while ((if_fp.busy || if_rr.busy) && k < max_cyc) begin
      cyc();
      k++;
    end
    check_eq("wait_idle_busy", 32'(if_fp.busy | if_rr.busy), 32'd0);
    check_eq("fp_sb_left", 32'(q_fp.size()), 32'd0);
    check_eq("rr_sb_left", 32'(q_rr.size()), 32'd0);
  endtask

  // Fixed-priority monitor: a handshake seen at negedge completes on the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if_fp.out_valid && if_fp.out_ready) begin
      if (q_fp.size() == 0) begin
        check_eq("fp_sb_underflow", 32'(q_fp.size()), 32'd1);
      end else begin
        e = q_fp.pop_front();
        check_eq("fp_idx", 32'(if_fp.out_idx), 32'(e.idx));
        check_eq("fp_onehot", 32'(if_fp.out_onehot), 32'd1 << e.idx);
        check_eq("fp_multi", 32'(if_fp.out_multi), 32'(e.multi));
      end
    end
  end

  // Round-robin monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if_rr.out_valid && if_rr.out_ready) begin
      if (q_rr.size() == 0) begin
        check_eq("rr_sb_underflow", 32'(q_rr.size()), 32'd1);
      end else begin
        e = q_rr.pop_front();
        check_eq("rr_idx", 32'(if_rr.out_idx), 32'(e.idx));
        check_eq("rr_onehot", 32'(if_rr.out_onehot), 32'd1 << e.idx);
        check_eq("rr_multi", 32'(if_rr.out_multi), 32'(e.multi));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with all requests high
    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 1'b1);
    cyc(2);
    check_eq("rst_valid", 32'(if_fp.out_valid), 32'd0);
    check_eq("rst_idx", 32'(if_fp.out_idx), 32'd0);
    check_eq("rst_onehot", 32'(if_fp.out_onehot), 32'd0);
    check_eq("rst_multi", 32'(if_fp.out_multi), 32'd0);
    check_eq("rst_busy", 32'(if_fp.busy), 32'd0);
    check_eq("rst_rr_valid", 32'(if_rr.out_valid), 32'd0);
    check_eq("rst_rr_busy", 32'(if_rr.busy), 32'd0);
    for (int i = 0; i < 8; i++) push2(i, i < 7);
    rst_n = 1'b1;
    cyc();
    check_eq("post_rst_idx", 32'(if_fp.out_idx), 32'd0);
    check_eq("post_rst_multi", 32'(if_fp.out_multi), 32'd1);
    drive(1'b1, 8'h00, 1'b1);
    wait_idle(20);

    // Multi-hot single pulse
    push2(2, 1'b1); push2(5, 1'b1); push2(7, 1'b0);
    drive(1'b1, 8'hA4, 1'b1);
    cyc();
    check_eq("a4_first_idx", 32'(if_fp.out_idx), 32'd2);
    drive(1'b1, 8'h00, 1'b1);
    wait_idle(10);
    check_eq("a4_valid_low", 32'(if_fp.out_valid), 32'd0);
    check_eq("a4_idx_hold", 32'(if_fp.out_idx), 32'd7);

    // Stall accumulates new requests
    push2(0, 1'b0); push2(7, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    cyc();
    drive(1'b1, 8'h80, 1'b0);
    cyc();
    drive(1'b1, 8'h00, 1'b0);
    cyc();
    check_eq("stall_valid", 32'(if_fp.out_valid), 32'd1);
    check_eq("stall_idx", 32'(if_fp.out_idx), 32'd0);
    check_eq("stall_busy", 32'(if_fp.busy), 32'd1);
    check_eq("stall_rr_idx", 32'(if_rr.out_idx), 32'd0);
    drive(1'b1, 8'h00, 1'b1);
    cyc();
    check_eq("stall_release_idx", 32'(if_fp.out_idx), 32'd7);
    wait_idle(10);

    // Held requests: fixed keeps granting 0, round-robin alternates
    for (int i = 0; i < 4; i++) push_fp(0, 1'b1);
    push_fp(4, 1'b0);
    push_rr(0, 1'b1); push_rr(4, 1'b1); push_rr(0, 1'b1); push_rr(4, 1'b1);
    push_rr(0, 1'b0);
    drive(1'b1, 8'h11, 1'b1);
    cyc(2);
    check_eq("hold_fp_idx", 32'(if_fp.out_idx), 32'd0);
    check_eq("hold_rr_idx", 32'(if_rr.out_idx), 32'd4);
    cyc(2);
    drive(1'b1, 8'h00, 1'b1);
    wait_idle(10);

    // Capture disabled: pending bit drains, new request ignored
    push2(0, 1'b0); push2(6, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    cyc();
    drive(1'b1, 8'h40, 1'b0);
    cyc();
    drive(1'b0, 8'h08, 1'b1);
    cyc();
    check_eq("en0_drain_idx", 32'(if_fp.out_idx), 32'd6);
    wait_idle(10);
    cyc(3);
    check_eq("en0_valid", 32'(if_fp.out_valid), 32'd0);
    check_eq("en0_busy", 32'(if_fp.busy | if_rr.busy), 32'd0);
    check_eq("en0_idx_hold", 32'(if_fp.out_idx), 32'd6);

    // Asynchronous reset mid-stall
    drive(1'b1, 8'h01, 1'b0);
    cyc();
    drive(1'b1, 8'h30, 1'b0);
    cyc();
    drive(1'b1, 8'h00, 1'b0);
    check_eq("pre_arst_valid", 32'(if_fp.out_valid), 32'd1);
    check_eq("pre_arst_busy", 32'(if_fp.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(if_fp.out_valid), 32'd0);
    check_eq("arst_busy", 32'(if_fp.busy), 32'd0);
    check_eq("arst_idx", 32'(if_fp.out_idx), 32'd0);
    check_eq("arst_onehot", 32'(if_fp.out_onehot), 32'd0);
    check_eq("arst_rr_busy", 32'(if_rr.busy), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    drive(1'b1, 8'h00, 1'b1);
    cyc(3);
    check_eq("post_arst_valid", 32'(if_fp.out_valid | if_rr.out_valid), 32'd0);
    check_eq("post_arst_busy", 32'(if_fp.busy | if_rr.busy), 32'd0);
    push2(1, 1'b0);
    drive(1'b1, 8'h02, 1'b1);
    cyc();
    check_eq("post_arst_idx", 32'(if_fp.out_idx), 32'd1);
    drive(1'b1, 8'h00, 1'b1);
    wait_idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
